// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU op codes, widths and slot state for alu_share_arbiter.
// ALU_ILLEGAL_OP_CHECK_EN enables the op_legal() decode in the top.
package alu_share_arbiter_pkg;

  localparam int DW = 32;
  localparam int CW = 4;

  localparam logic [CW-1:0] OP_AND = 4'b0000;
  localparam logic [CW-1:0] OP_OR  = 4'b0001;
  localparam logic [CW-1:0] OP_ADD = 4'b0010;
  localparam logic [CW-1:0] OP_SUB = 4'b0110;
  localparam logic [CW-1:0] OP_SLT = 4'b0111;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_e;

  function automatic logic op_legal(
    input logic [CW-1:0] op
  );
    case (op)
      OP_AND, OP_OR, OP_ADD,
      OP_SUB, OP_SLT: op_legal = 1'b1;
      default:        op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// N-way round-robin grant generator; the pointer
// names the highest-priority requester.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] &&
            ((int'(ptr_q) + k) % N) == i) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          ptr_d  = PW'((i + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among N_REQ requesters.
// Define ALU_ILLEGAL_OP_CHECK_EN to flag illegal ops via rsp_err.
module alu_share_arbiter #(
  parameter int N_REQ = 2,
  parameter int DW    = alu_share_arbiter_pkg::DW,
  parameter int CW    = alu_share_arbiter_pkg::CW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  input  logic [N_REQ*CW-1:0] req_op,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [N_REQ*DW-1:0] rsp_result,
  output logic [N_REQ-1:0]    rsp_zero,
  output logic [N_REQ-1:0]    rsp_err,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [CW-1:0]       alu_ctrl,
  input  logic [DW-1:0]       alu_result,
  input  logic                alu_zero
);

  import alu_share_arbiter_pkg::*;

  slot_e             state_q [N_REQ];
  slot_e             state_d [N_REQ];
  logic [DW-1:0]     res_q   [N_REQ];
  logic [N_REQ-1:0]  zero_q;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  gnt;
  logic [CW-1:0]     gnt_op;
  logic [DW-1:0]     cap_res;
  logic              cap_zero;

  // A full slot may be reloaded in the cycle it drains.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = !reset && req_valid[i] &&
                (state_q[i] == SLOT_EMPTY ||
                 rsp_ready[i]);
    end
  end

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (elig),
    .gnt   (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    gnt_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        alu_a  = req_a[i*DW +: DW];
        alu_b  = req_b[i*DW +: DW];
        gnt_op = req_op[i*CW +: CW];
      end
    end
  end

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic             illegal;
  logic [N_REQ-1:0] err_q;

  assign illegal  = (|gnt) && !op_legal(gnt_op);
  assign alu_ctrl = illegal ? OP_AND : gnt_op;
  assign cap_res  = illegal ? '0 : alu_result;
  assign cap_zero = illegal ? 1'b0 : alu_zero;
  assign rsp_err  = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i]) err_q[i] <= illegal;
      end
    end
  end
`else
  assign alu_ctrl = gnt_op;
  assign cap_res  = alu_result;
  assign cap_zero = alu_zero;
  assign rsp_err  = '0;
`endif

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      state_d[i] = state_q[i];
      if (gnt[i]) begin
        state_d[i] = SLOT_FULL;
      end else if (state_q[i] == SLOT_FULL &&
                   rsp_ready[i]) begin
        state_d[i] = SLOT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        state_q[i] <= SLOT_EMPTY;
        res_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        state_q[i] <= state_d[i];
        if (gnt[i]) begin
          res_q[i]  <= cap_res;
          zero_q[i] <= cap_zero;
        end
      end
    end
  end

  always_comb begin
    rsp_valid  = '0;
    rsp_result = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i]            = state_q[i] == SLOT_FULL;
      rsp_result[i*DW +: DW]  = res_q[i];
    end
  end

  assign rsp_zero = zero_q;

endmodule
